// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel streamer: FSM state encoding and the
// per-pixel sideband flag bundle that travels with each pixel.
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } flags_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO holding a pixel plus its sideband flags; the head entry
// stays put until popped, which keeps the output stable under backpressure.
module pix_skid_fifo
    import pixel_stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  flags_t        i_flags,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output flags_t        o_flags,
    output logic          o_full,
    output logic          o_empty,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_data [2];
    flags_t        r_flags [2];
    logic          r_wr;
    logic          r_rd;
    logic [1:0]    r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_cnt != 2'd0);
    assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_cnt      <= 2'd0;
            r_data[0]  <= '0;
            r_data[1]  <= '0;
            r_flags[0] <= '0;
            r_flags[1] <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr]  <= i_data;
                r_flags[r_wr] <= i_flags;
                r_wr          <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_data  = r_data[r_rd];
    assign o_flags = r_flags[r_rd];
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);
    assign o_count = r_cnt;

endmodule

// File: rtl/pixel_streamer.sv
// Streams a frame from memory in raster order through a 2-entry FIFO.
// Define PIXEL_STREAMER_PAD_EN to emit a one-pixel zero border.
module pixel_streamer
    import pixel_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  done
);

`ifdef PIXEL_STREAMER_PAD_EN
    localparam int FW = IMG_W + 2;
    localparam int FH = IMG_H + 2;
`else
    localparam int FW = IMG_W;
    localparam int FH = IMG_H;
`endif
    localparam int CW = $clog2(FW);
    localparam int RW = $clog2(FH);

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inflight;
    logic                  r_pend_pad;
    flags_t                r_pend_flags;

    logic                  w_slot;
    logic                  w_read;
    logic                  w_pad;
    logic                  w_eol;
    logic                  w_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic                  w_empty;
    logic                  w_full;
    logic [1:0]            w_cnt;
    logic [2:0]            w_credit;
    flags_t                w_slot_flags;
    flags_t                w_head_flags;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [DATA_WIDTH-1:0] w_push_data;

    assign w_eol  = (r_col == CW'(FW - 1));
    assign w_last = w_eol && (r_row == RW'(FH - 1));

`ifdef PIXEL_STREAMER_PAD_EN
    assign w_pad = (r_col == '0) || w_eol ||
                   (r_row == '0) || (r_row == RW'(FH - 1));
    assign w_push_data = r_pend_pad ? '0 : mem_rdata;
`else
    assign w_pad = 1'b0;
    assign w_push_data = mem_rdata;
`endif

    assign w_slot_flags.sof = (r_col == '0) && (r_row == '0);
    assign w_slot_flags.eol = w_eol;
    assign w_slot_flags.eof = w_last;

    // Credit counts occupancy left after this cycle's pop, so a steady
    // ready_in keeps one pixel per cycle without ever overfilling.
    assign w_valid  = !w_empty && !rst;
    assign w_pop    = w_valid && ready_in;
    assign w_credit = 3'(w_cnt) - 3'(w_pop) + 3'(r_inflight);
    assign w_slot   = (r_state == ST_FETCH) && (w_credit < 3'd2);
    assign w_read   = w_slot && !w_pad;
    assign w_push   = r_inflight && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_inflight   <= 1'b0;
            r_pend_pad   <= 1'b0;
            r_pend_flags <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_slot;
            if (w_slot) begin
                r_pend_flags <= w_slot_flags;
                r_pend_pad   <= w_pad;
                if (w_last) begin
                    r_col <= '0;
                    r_row <= '0;
                end else if (w_eol) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (w_last) begin
                    r_addr <= '0;
                end else if (w_read) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_next = ST_FETCH;
            ST_FETCH:  if (w_slot && w_last) w_next = ST_DRAIN;
            ST_DRAIN:  if (w_credit == 3'd0) w_next = ST_FINISH;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    pix_skid_fifo #(
        .DW (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_flags (r_pend_flags),
        .i_pop   (w_pop),
        .o_data  (w_head_data),
        .o_flags (w_head_flags),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    assign mem_rd_en = w_read && !rst;
    assign mem_addr  = rst ? '0 : r_addr;
    assign valid_out = w_valid;
    assign pixel_out = w_valid ? w_head_data : '0;
    assign sof       = w_valid && w_head_flags.sof;
    assign eol       = w_valid && w_head_flags.eol;
    assign eof       = w_valid && w_head_flags.eof;
    assign busy      = !rst && (r_state != ST_IDLE);
    assign done      = !rst && (r_state == ST_FINISH);

    logic w_unused;
    assign w_unused = w_full;

endmodule
